// File: rtl/page_read_exec.sv
// page_read_exec: runs one NAND page read at a time -- command/address issue, busy wait, data transfer.
// Define PAGE_BUSY_TIMEOUT_EN to bound the busy wait to TIMEOUT_CYC cycles.
module page_read_exec #(
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_page_cmd_valid,
  input  logic [15:0]       i_page_cmd,
  input  logic              i_page_cmd_last,
  input  logic [15:0]       i_page_cmd_id,
  input  logic [47:0]       i_page_addr,
  input  logic [31:0]       i_page_cmd_param,
  output logic              o_page_cmd_ready,
  output logic              o_nf_cmd_valid,
  output logic [7:0]        o_nf_opcode,
  output logic [47:0]       o_nf_addr,
  output logic [2:0]        o_nf_way,
  input  logic              i_nf_cmd_ready,
  input  logic              i_nf_rb,
  input  logic              i_nf_data_valid,
  input  logic [DW-1:0]     i_nf_data,
  output logic              o_nf_data_ready,
  output logic              o_rdata_valid,
  output logic [DW-1:0]     o_rdata,
  output logic [DW/8-1:0]   o_rdata_keep,
  output logic              o_rdata_last,
  output logic [15:0]       o_rdata_id,
  input  logic              i_rdata_ready,
  output logic              o_page_done,
  output logic              o_err
);
  localparam int BYTES = DW / 8;

  typedef enum logic [2:0] {IDLE, ISSUE, BUSY_WAIT, XFER, DONE} state_t;

  state_t       state_q, state_d;
  logic         ready_q, ready_d;
  logic [7:0]   op_q, op_d;
  logic [15:0]  id_q, id_d;
  logic [47:0]  addr_q, addr_d;
  logic [15:0]  len_q, len_d;
  logic [2:0]   way_q, way_d;
  logic         last_q, last_d;
  logic         err_q, err_d;
  logic [1:0]   guard_q, guard_d;
  logic [15:0]  beat_q, beat_d;
`ifdef PAGE_BUSY_TIMEOUT_EN
  logic [31:0]  tmo_q, tmo_d;
`endif

  logic [16:0]  len_round;
  logic [15:0]  total_beats;
  logic [15:0]  len_rem;
  logic         final_beat;
  logic         beat_fire;
  logic         accept;
  logic         bad_cmd;
  logic         unused_bits;

  // Column and the opcode's low byte travel inside the address / are don't-care here.
  assign unused_bits = ^{i_page_cmd[7:0], i_page_cmd_param[15:4], 32'(TIMEOUT_CYC)};

  assign len_round   = {1'b0, len_q} + 17'(BYTES - 1);
  assign total_beats = 16'(len_round / 17'(BYTES));
  assign len_rem     = len_q % 16'(BYTES);
  assign final_beat  = (beat_q == total_beats - 16'd1);
  assign beat_fire   = i_nf_data_valid && i_rdata_ready;
  assign accept      = i_page_cmd_valid && ready_q;
  assign bad_cmd     = !((i_page_cmd[15:8] == 8'h30) || (i_page_cmd[15:8] == 8'h35))
                       || !i_page_cmd_param[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      op_q    <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      way_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      guard_q <= '0;
      beat_q  <= '0;
`ifdef PAGE_BUSY_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      op_q    <= op_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      way_q   <= way_d;
      last_q  <= last_d;
      err_q   <= err_d;
      guard_q <= guard_d;
      beat_q  <= beat_d;
`ifdef PAGE_BUSY_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    way_d   = way_q;
    last_d  = last_q;
    err_d   = err_q;
    guard_d = guard_q;
    beat_d  = beat_q;
`ifdef PAGE_BUSY_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = i_page_cmd[15:8];
          id_d    = i_page_cmd_id;
          addr_d  = i_page_addr;
          len_d   = i_page_cmd_param[31:16];
          way_d   = i_page_cmd_param[3:1];
          last_d  = i_page_cmd_last;
          err_d   = bad_cmd;
          beat_d  = '0;
          state_d = bad_cmd ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (i_nf_cmd_ready) begin
          state_d = BUSY_WAIT;
          guard_d = '0;
`ifdef PAGE_BUSY_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      BUSY_WAIT: begin
        // R/B# may not have fallen yet right after the command (tWB), so its first two samples are ignored.
        if (guard_q != 2'd2) begin
          guard_d = guard_q + 2'd1;
        end else if (i_nf_rb) begin
          state_d = ((op_q == 8'h30) && (len_q != 16'd0)) ? XFER : DONE;
        end
`ifdef PAGE_BUSY_TIMEOUT_EN
        if (state_d == BUSY_WAIT) begin
          if (tmo_q == 32'(TIMEOUT_CYC - 1)) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
        end
`endif
      end
      XFER: begin
        if (beat_fire) begin
          if (final_beat) state_d = DONE;
          else            beat_d  = beat_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    o_page_cmd_ready = ready_q;
    o_nf_cmd_valid   = (state_q == ISSUE);
    o_nf_opcode      = op_q;
    o_nf_addr        = addr_q;
    o_nf_way         = way_q;
    o_rdata_id       = id_q;
    o_rdata_valid    = 1'b0;
    o_nf_data_ready  = 1'b0;
    o_rdata          = '0;
    o_rdata_keep     = '0;
    o_rdata_last     = 1'b0;
    if (state_q == XFER) begin
      o_rdata_valid   = i_nf_data_valid;
      o_nf_data_ready = i_rdata_ready;
      o_rdata         = i_nf_data;
      for (int b = 0; b < BYTES; b++) begin
        o_rdata_keep[b] = !final_beat || (len_rem == 16'd0) || (16'(b) < len_rem);
      end
      o_rdata_last    = final_beat && last_q;
    end
    o_page_done = (state_q == DONE);
    o_err       = (state_q == DONE) && err_q;
  end

endmodule

// File: tb/tb_page_read_exec.sv
// Randomized bench for page_read_exec: a transaction-level model predicts channel commands,
// beat counts, keeps and completion status; a per-cycle monitor compares the DUT against it.
module tb_page_read_exec;
  localparam int DW    = 32;
  localparam int BYTES = DW / 8;
`ifdef PAGE_BUSY_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1000000;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              i_page_cmd_valid;
  logic [15:0]       i_page_cmd;
  logic              i_page_cmd_last;
  logic [15:0]       i_page_cmd_id;
  logic [47:0]       i_page_addr;
  logic [31:0]       i_page_cmd_param;
  logic              o_page_cmd_ready;
  logic              o_nf_cmd_valid;
  logic [7:0]        o_nf_opcode;
  logic [47:0]       o_nf_addr;
  logic [2:0]        o_nf_way;
  logic              i_nf_cmd_ready;
  logic              i_nf_rb;
  logic              i_nf_data_valid;
  logic [DW-1:0]     i_nf_data;
  logic              o_nf_data_ready;
  logic              o_rdata_valid;
  logic [DW-1:0]     o_rdata;
  logic [BYTES-1:0]  o_rdata_keep;
  logic              o_rdata_last;
  logic [15:0]       o_rdata_id;
  logic              i_rdata_ready;
  logic              o_page_done;
  logic              o_err;

  always #5 clk = ~clk;

  page_read_exec #(.DW(DW), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .i_page_cmd_valid(i_page_cmd_valid), .i_page_cmd(i_page_cmd), .i_page_cmd_last(i_page_cmd_last),
    .i_page_cmd_id(i_page_cmd_id), .i_page_addr(i_page_addr), .i_page_cmd_param(i_page_cmd_param),
    .o_page_cmd_ready(o_page_cmd_ready),
    .o_nf_cmd_valid(o_nf_cmd_valid), .o_nf_opcode(o_nf_opcode), .o_nf_addr(o_nf_addr), .o_nf_way(o_nf_way),
    .i_nf_cmd_ready(i_nf_cmd_ready), .i_nf_rb(i_nf_rb),
    .i_nf_data_valid(i_nf_data_valid), .i_nf_data(i_nf_data), .o_nf_data_ready(o_nf_data_ready),
    .o_rdata_valid(o_rdata_valid), .o_rdata(o_rdata), .o_rdata_keep(o_rdata_keep),
    .o_rdata_last(o_rdata_last), .o_rdata_id(o_rdata_id), .i_rdata_ready(i_rdata_ready),
    .o_page_done(o_page_done), .o_err(o_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // ---------------- channel / downstream stimulus ----------------
  bit full_rate  = 1'b0;
  int rb_delay   = 0;
  bit hold_busy  = 1'b0;
  bit tmo_expect = 1'b0;
  bit hs_next    = 1'b0;
  int rb_cnt     = 0;

  initial begin
    i_nf_cmd_ready  = 1'b0;
    i_nf_rb         = 1'b1;
    i_nf_data_valid = 1'b0;
    i_nf_data       = '0;
    i_rdata_ready   = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    i_nf_cmd_ready  = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
    i_nf_data_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
    i_rdata_ready   = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
    i_nf_data       = DW'($urandom);
    if (rst) begin
      i_nf_rb = 1'b1;
      rb_cnt  = 0;
    end else if (hs_next) begin
      i_nf_rb = 1'b0;
      rb_cnt  = (rb_delay > 0) ? rb_delay - 1 : int'($urandom_range(0, 12));
    end else if (rb_cnt > 0) begin
      rb_cnt--;
    end else if (!hold_busy) begin
      i_nf_rb = 1'b1;
    end
  end

  // ---------------- reference model + monitor ----------------
  bit               busy = 1'b0, issued = 1'b0, rst_prev = 1'b0;
  bit               exp_bad, exp_tmo, exp_last;
  logic [7:0]       exp_op;
  logic [15:0]      exp_id;
  logic [47:0]      exp_addr;
  logic [2:0]       exp_way;
  int               exp_len = 0, exp_total = 0, beats_seen = 0;
  int               done_cnt = 0, cyc = 0, issue_cyc = 0;
  int               pg_beats = 0, pg_issues = 0, pg_rlast = 0, pg_lat = 0;
  bit               pg_err = 1'b0;
  logic [BYTES-1:0] pg_keep = '0;
  logic [7:0]       pg_op = '0;
  logic [2:0]       pg_way = '0;

  function automatic logic [BYTES-1:0] keep_for(input int k, input int tot, input int len);
    int r;
    logic [BYTES-1:0] m;
    r = len % BYTES;
    m = '1;
    if (k == tot - 1 && r != 0) m = BYTES'((1 << r) - 1);
    return m;
  endfunction

  always @(negedge clk) begin
    bit allowed;
    cyc++;
    hs_next = 1'b0;
    if (rst) begin
      if (rst_prev) begin
        chk_eq("rst_ready", o_page_cmd_ready, 0);
        chk_eq("rst_outputs", {o_nf_cmd_valid, o_rdata_valid, o_page_done, o_err, o_rdata_last,
                               |o_nf_opcode, |o_nf_addr, |o_nf_way, |o_rdata_id, |o_rdata_keep}, 0);
      end
      rst_prev = 1'b1;
      busy = 1'b0; issued = 1'b0; beats_seen = 0;
    end else begin
      rst_prev = 1'b0;
      chk_eq("ready_low_while_busy", busy && o_page_cmd_ready, 0);

      if (o_nf_cmd_valid) begin
        chk_eq("nf_cmd_expected", busy && !exp_bad && !issued, 1);
        if (i_nf_cmd_ready) begin
          chk_eq("nf_opcode", o_nf_opcode, exp_op);
          chk_eq("nf_addr", o_nf_addr, exp_addr);
          chk_eq("nf_way", o_nf_way, exp_way);
          issued = 1'b1; pg_issues++; pg_op = o_nf_opcode; pg_way = o_nf_way;
          issue_cyc = cyc; hs_next = 1'b1;
        end
      end

      allowed = busy && issued && (beats_seen < exp_total) && i_nf_rb;
      if (busy && beats_seen > 0 && beats_seen < exp_total) begin
        chk_eq("xfer_valid_pass", o_rdata_valid, i_nf_data_valid);
        chk_eq("xfer_ready_pass", o_nf_data_ready, i_rdata_ready);
      end
      if (i_nf_data_valid && o_nf_data_ready)
        chk_eq("beat_both_sides", o_rdata_valid && i_rdata_ready, 1);
      if (o_rdata_valid) begin
        chk_eq("rdata_allowed", allowed, 1);
        chk_eq("rdata_value", o_rdata, i_nf_data);
        chk_eq("rdata_id", o_rdata_id, exp_id);
        if (i_rdata_ready && allowed) begin
          chk_eq("rdata_keep", o_rdata_keep, keep_for(beats_seen, exp_total, exp_len));
          chk_eq("rdata_last", o_rdata_last, exp_last && (beats_seen == exp_total - 1));
          pg_keep = o_rdata_keep;
          if (o_rdata_last) pg_rlast++;
          beats_seen++;
        end
      end

      if (o_err) chk_eq("err_with_done", o_page_done, 1);
      if (o_page_done) begin
        chk_eq("done_while_busy", busy, 1);
        chk_eq("done_beat_count", beats_seen, exp_total);
        chk_eq("done_issue", issued, !exp_bad);
        chk_eq("done_err", o_err, exp_bad || exp_tmo);
        pg_beats = beats_seen; pg_err = o_err; pg_lat = cyc - issue_cyc;
        busy = 1'b0; done_cnt++;
      end

      if (i_page_cmd_valid && o_page_cmd_ready) begin
        chk_eq("accept_while_busy", busy, 0);
        busy = 1'b1; issued = 1'b0; beats_seen = 0;
        exp_op    = i_page_cmd[15:8];
        exp_id    = i_page_cmd_id;
        exp_addr  = i_page_addr;
        exp_way   = i_page_cmd_param[3:1];
        exp_len   = int'(i_page_cmd_param[31:16]);
        exp_last  = i_page_cmd_last;
        exp_bad   = !(exp_op == 8'h30 || exp_op == 8'h35) || !i_page_cmd_param[0];
        exp_tmo   = tmo_expect && !exp_bad;
        exp_total = (!exp_bad && !exp_tmo && exp_op == 8'h30) ? (exp_len + BYTES - 1) / BYTES : 0;
        pg_beats = 0; pg_issues = 0; pg_rlast = 0; pg_keep = '0;
        pg_op = '0; pg_way = '0; pg_err = 1'b0; pg_lat = 0;
      end
    end
  end

  // ---------------- scheduler-side driver ----------------
  task automatic send_page(input logic [15:0] cmd, input logic [15:0] len, input logic [2:0] way,
                           input logic en, input logic last, input logic [15:0] id, input logic [47:0] addr);
    bit got;
    i_page_cmd       = cmd;
    i_page_cmd_param = {len, 12'($urandom_range(0, 4095)), way, en};
    i_page_cmd_last  = last;
    i_page_cmd_id    = id;
    i_page_addr      = addr;
    i_page_cmd_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50000 && !got; i++) begin
      @(negedge clk);
      got = o_page_cmd_ready;
    end
    chk_eq("cmd_accepted", got, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d0, input int n);
    for (int i = 0; i < 40000 && done_cnt < d0 + n; i++) @(posedge clk);
    chk_eq("page_done_seen", done_cnt >= d0 + n, 1);
    #1;
  endtask

  task automatic run_page(input logic [15:0] cmd, input logic [15:0] len, input logic [2:0] way,
                          input logic en, input logic last, input logic [15:0] id, input logic [47:0] addr);
    int d0;
    d0 = done_cnt;
    send_page(cmd, len, way, en, last, id, addr);
    i_page_cmd_valid = 1'b0;
    wait_done(d0, 1);
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int r;
    logic [7:0] op;
    rst = 1'b1;
    i_page_cmd_valid = 1'b0;
    i_page_cmd = '0; i_page_cmd_last = 1'b0; i_page_cmd_id = '0;
    i_page_addr = '0; i_page_cmd_param = '0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Full page, 4096 bytes, rb returns ~10 cycles after issue
    full_rate = 1'b1; rb_delay = 10;
    d0 = done_cnt;
    run_page(16'h3000, 16'd4096, 3'h6, 1'b1, 1'b1, 16'h0101, 48'h0000_1234_5678);
    chk_eq("p1_opcode", pg_op, 8'h30);
    chk_eq("p1_way", pg_way, 3'h6);
    chk_eq("p1_beats", pg_beats, 1024);
    chk_eq("p1_keep", pg_keep, 4'hF);
    chk_eq("p1_last_count", pg_rlast, 1);
    chk_eq("p1_done_count", done_cnt - d0, 1);

    // Partial page under 50% backpressure
    full_rate = 1'b0; rb_delay = 0;
    run_page(16'h3000, 16'd4097, 3'h2, 1'b1, 1'b0, 16'h0202, 48'h0000_0000_ABCD);
    chk_eq("p2_beats", pg_beats, 1025);
    chk_eq("p2_keep", pg_keep, 4'b0001);
    chk_eq("p2_last_count", pg_rlast, 0);

    // Copyback: command only, no data
    run_page(16'h3500, 16'd0, 3'h1, 1'b1, 1'b1, 16'h0303, 48'h0000_0000_0042);
    chk_eq("cb_opcode", pg_op, 8'h35);
    chk_eq("cb_issues", pg_issues, 1);
    chk_eq("cb_beats", pg_beats, 0);
    chk_eq("cb_err", pg_err, 0);

    // Bad opcode and disabled param
    run_page(16'h8000, 16'd512, 3'h0, 1'b1, 1'b1, 16'h0404, 48'h1);
    chk_eq("badop_err", pg_err, 1);
    chk_eq("badop_issues", pg_issues, 0);
    run_page(16'h3000, 16'd512, 3'h0, 1'b0, 1'b1, 16'h0505, 48'h2);
    chk_eq("noen_err", pg_err, 1);
    chk_eq("noen_issues", pg_issues, 0);

    // Single byte
    run_page(16'h3000, 16'd1, 3'h3, 1'b1, 1'b1, 16'h0606, 48'h3);
    chk_eq("len1_beats", pg_beats, 1);
    chk_eq("len1_keep", pg_keep, 4'b0001);
    chk_eq("len1_last_count", pg_rlast, 1);

    // Maximum length
    full_rate = 1'b1;
    run_page(16'h3000, 16'hFFFF, 3'h7, 1'b1, 1'b1, 16'h0707, 48'h4);
    chk_eq("max_beats", pg_beats, 16384);
    chk_eq("max_keep", pg_keep, 4'b0111);

    // Back-to-back commands from the scheduler
    full_rate = 1'b0;
    d0 = done_cnt;
    send_page(16'h3000, 16'd64, 3'h1, 1'b1, 1'b0, 16'h0808, 48'h5);
    send_page(16'h3000, 16'd8, 3'h2, 1'b1, 1'b1, 16'h0909, 48'h6);
    i_page_cmd_valid = 1'b0;
    wait_done(d0, 2);
    chk_eq("b2b_done_count", done_cnt - d0, 2);
    chk_eq("b2b_second_beats", pg_beats, 2);

    // Random mix
    for (int n = 0; n < 25; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6)      op = 8'h30;
      else if (r < 8) op = 8'h35;
      else begin
        op = 8'($urandom_range(0, 255));
        if (op == 8'h30 || op == 8'h35) op = 8'h80;
      end
      full_rate = ($urandom_range(0, 3) == 0);
      run_page({op, 8'($urandom_range(0, 255))}, 16'($urandom_range(0, 300)), 3'($urandom_range(0, 7)),
               ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 16'($urandom), {16'h0, 32'($urandom)});
    end

`ifdef PAGE_BUSY_TIMEOUT_EN
    hold_busy = 1'b1; tmo_expect = 1'b1; full_rate = 1'b1;
    run_page(16'h3000, 16'd64, 3'h4, 1'b1, 1'b1, 16'h0A0A, 48'h7);
    chk_eq("tmo_err", pg_err, 1);
    chk_eq("tmo_beats", pg_beats, 0);
    chk_eq("tmo_latency", pg_lat, TMO + 1);
    hold_busy = 1'b0; tmo_expect = 1'b0;
`endif

    // Reset in the middle of a transfer
    full_rate = 1'b0;
    d0 = done_cnt;
    send_page(16'h3000, 16'd2000, 3'h5, 1'b1, 1'b1, 16'h0B0B, 48'h8);
    i_page_cmd_valid = 1'b0;
    for (int i = 0; i < 20000 && beats_seen <= 5; i++) @(posedge clk);
    chk_eq("midxfer_reached", beats_seen > 5, 1);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_eq("midxfer_no_done", done_cnt - d0, 0);
    chk_eq("midxfer_no_last", pg_rlast, 0);
    run_page(16'h3000, 16'd8, 3'h0, 1'b1, 1'b1, 16'h0C0C, 48'h9);
    chk_eq("post_rst_beats", pg_beats, 2);
    chk_eq("post_rst_keep", pg_keep, 4'hF);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
